// File: rtl/hbm_pcie_reset_sequencer.sv
// ---------------------------------------------------------------------------
// hbm_pcie_reset_sequencer
//
// Purpose:
//   Sequences reset release for the HBM subsystem and the user kernel region
//   after PCIe PERST# deasserts. HBM reset is held for a fixed number of
//   cycles, then the sequencer waits for HBM calibration (with a timeout),
//   then holds the user region in reset for a fixed number of cycles before
//   entering RUN. A catastrophic-temperature indication from the HBM latches
//   a sticky trip output for the board and parks the sequencer in FAULT
//   until ap_rst_n.
//
// Ports:
//   ap_clk          in   free-running sequencer clock
//   ap_rst_n        in   asynchronous active-low reset
//   pcie_perstn     in   PCIe PERST#, active low, asynchronous to ap_clk
//   hbm_cal_done    in   HBM calibration complete, asynchronous
//   hbm_cattrip_in  in   HBM catastrophic-temperature indicator, asynchronous
//   hbm_rst_n       out  reset to the HBM controller/IP, active low
//   user_rst_n      out  reset to the user kernel region, active low
//   HBM_CATTRIP     out  sticky temperature trip to the board pin
//   seq_state       out  current FSM state encoding (debug)
//   cal_err         out  sticky calibration-timeout flag
//
// Parameters:
//   SYNC_STAGES      synchronizer depth for the asynchronous inputs (2..4)
//   HBM_RST_CYCLES   cycles hbm_rst_n is held low after PERST# release (>=1)
//   CAL_TIMEOUT      cycles to wait for calibration before flagging (>=2)
//   USER_RST_CYCLES  cycles user_rst_n is held low after calibration (>=1)
//   CNT_W            counter width, 2**CNT_W must exceed every cycle count
// ---------------------------------------------------------------------------
module hbm_pcie_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int HBM_RST_CYCLES  = 64,
  parameter int CAL_TIMEOUT     = 1048576,
  parameter int USER_RST_CYCLES = 16,
  parameter int CNT_W           = 21
) (
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  input  logic       pcie_perstn,
  input  logic       hbm_cal_done,
  input  logic       hbm_cattrip_in,
  output logic       hbm_rst_n,
  output logic       user_rst_n,
  output logic       HBM_CATTRIP,
  output logic [2:0] seq_state,
  output logic       cal_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HBM_RST  = 3'd1,
    S_WAIT_CAL = 3'd2,
    S_USER_RST = 3'd3,
    S_RUN      = 3'd4,
    S_CAL_ERR  = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  // Terminal counts: each timed state lasts exactly N cycles because the
  // counter starts at 0 on entry and the exit fires when it reaches N-1.
  localparam logic [CNT_W-1:0] HBM_LAST  = CNT_W'(HBM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] USER_LAST = CNT_W'(USER_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // -------------------------------------------------------------------------
  // Input synchronizers (all reset to 0)
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_perst_sync;
  logic [SYNC_STAGES-1:0] r_cal_sync;
  logic [SYNC_STAGES-1:0] r_trip_sync;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_perst_sync <= '0;
      r_cal_sync   <= '0;
      r_trip_sync  <= '0;
    end else begin
      r_perst_sync <= {r_perst_sync[SYNC_STAGES-2:0], pcie_perstn};
      r_cal_sync   <= {r_cal_sync[SYNC_STAGES-2:0], hbm_cal_done};
      r_trip_sync  <= {r_trip_sync[SYNC_STAGES-2:0], hbm_cattrip_in};
    end
  end

  logic w_perst_s;
  logic w_cal_s;
  logic w_trip_s;

  assign w_perst_s = r_perst_sync[SYNC_STAGES-1];
  assign w_cal_s   = r_cal_sync[SYNC_STAGES-1];
  assign w_trip_s  = r_trip_sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Sequencer state, counter and registered outputs
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hbm_rst_n;
  logic             r_user_rst_n;
  logic             r_cattrip;
  logic             r_cal_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_hbm_rst_n_nxt;
  logic             w_user_rst_n_nxt;
  logic             w_cattrip_nxt;
  logic             w_cal_err_nxt;

  // Saturating increment: legal parameter sets never reach CNT_MAX, but the
  // counter must never wrap back into a terminal count.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_inc;
    w_cattrip_nxt = r_cattrip;
    w_cal_err_nxt = r_cal_err;

    if (w_trip_s) begin
      // Thermal trip overrides everything, from every state.
      w_state_nxt   = S_FAULT;
      w_cattrip_nxt = 1'b1;
      w_cnt_nxt     = '0;
    end else if (r_state == S_FAULT) begin
      // FAULT is left only through ap_rst_n; PERST# is deliberately ignored.
      w_state_nxt = S_FAULT;
      w_cnt_nxt   = r_cnt;
    end else if (!w_perst_s && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_cal_err_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_perst_s) begin
            w_state_nxt = S_HBM_RST;
          end
        end
        S_HBM_RST: begin
          if (r_cnt == HBM_LAST) begin
            w_state_nxt = S_WAIT_CAL;
            w_cnt_nxt   = '0;
          end
        end
        S_WAIT_CAL: begin
          // Calibration is tested first so it wins a tie with the timeout.
          if (w_cal_s) begin
            w_state_nxt = S_USER_RST;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CAL_LAST) begin
            w_state_nxt   = S_CAL_ERR;
            w_cal_err_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end
        end
        S_USER_RST: begin
          if (r_cnt == USER_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end
        end
        S_RUN: begin
          w_cnt_nxt = '0;
          // Losing calibration pulls the user region back into reset while
          // the HBM stays out of reset and calibration is awaited again.
          if (!w_cal_s) begin
            w_state_nxt = S_WAIT_CAL;
          end
        end
        S_CAL_ERR: begin
          w_cnt_nxt = r_cnt;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Reset outputs are decoded from the next state so they move on the
    // same edge as seq_state.
    w_hbm_rst_n_nxt  = (w_state_nxt == S_WAIT_CAL) ||
                       (w_state_nxt == S_USER_RST) ||
                       (w_state_nxt == S_RUN);
    w_user_rst_n_nxt = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hbm_rst_n  <= 1'b0;
      r_user_rst_n <= 1'b0;
      r_cattrip    <= 1'b0;
      r_cal_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hbm_rst_n  <= w_hbm_rst_n_nxt;
      r_user_rst_n <= w_user_rst_n_nxt;
      r_cattrip    <= w_cattrip_nxt;
      r_cal_err    <= w_cal_err_nxt;
    end
  end

  assign hbm_rst_n   = r_hbm_rst_n;
  assign user_rst_n  = r_user_rst_n;
  assign HBM_CATTRIP = r_cattrip;
  assign seq_state   = r_state;
  assign cal_err     = r_cal_err;

endmodule

// File: tb/tb_hbm_pcie_reset_sequencer.sv
module tb_hbm_pcie_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int HBM_N  = 4;
  localparam int CAL_N  = 8;
  localparam int USER_N = 3;
  localparam int CNT_W  = 8;

  logic       ap_clk;
  logic       ap_rst_n;
  logic       pcie_perstn;
  logic       hbm_cal_done;
  logic       hbm_cattrip_in;
  logic       hbm_rst_n;
  logic       user_rst_n;
  logic       HBM_CATTRIP;
  logic [2:0] seq_state;
  logic       cal_err;

  int passes;
  int total;

  hbm_pcie_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .HBM_RST_CYCLES (HBM_N),
    .CAL_TIMEOUT    (CAL_N),
    .USER_RST_CYCLES(USER_N),
    .CNT_W          (CNT_W)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .pcie_perstn   (pcie_perstn),
    .hbm_cal_done  (hbm_cal_done),
    .hbm_cattrip_in(hbm_cattrip_in),
    .hbm_rst_n     (hbm_rst_n),
    .user_rst_n    (user_rst_n),
    .HBM_CATTRIP   (HBM_CATTRIP),
    .seq_state     (seq_state),
    .cal_err       (cal_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Reference model: phase number plus a countdown of cycles left in the
  // current timed phase; synchronizers modelled as fixed-length delay queues.
  int m_phase;
  int m_left;
  bit m_trip;
  bit m_calerr;
  bit qp[$];
  bit qc[$];
  bit qt[$];

  function automatic void m_reset();
    m_phase  = 0;
    m_left   = 0;
    m_trip   = 1'b0;
    m_calerr = 1'b0;
    qp.delete();
    qc.delete();
    qt.delete();
    for (int i = 0; i < SYNC; i++) begin
      qp.push_back(1'b0);
      qc.push_back(1'b0);
      qt.push_back(1'b0);
    end
  endfunction

  function automatic void m_step();
    bit ps;
    bit cs;
    bit ts;
    if (!ap_rst_n) begin
      m_reset();
      return;
    end
    ps = qp.pop_front();
    cs = qc.pop_front();
    ts = qt.pop_front();
    qp.push_back(pcie_perstn);
    qc.push_back(hbm_cal_done);
    qt.push_back(hbm_cattrip_in);
    if (ts) begin
      m_phase = 6;
      m_trip  = 1'b1;
    end else if (m_phase == 6) begin
      m_phase = 6;
    end else if (!ps && m_phase != 0) begin
      m_phase  = 0;
      m_calerr = 1'b0;
    end else begin
      case (m_phase)
        0: if (ps) begin m_phase = 1; m_left = HBM_N; end
        1: begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_left = CAL_N; end
        end
        2: begin
          if (cs) begin
            m_phase = 3;
            m_left  = USER_N;
          end else begin
            m_left--;
            if (m_left == 0) begin m_phase = 5; m_calerr = 1'b1; end
          end
        end
        3: begin
          m_left--;
          if (m_left == 0) m_phase = 4;
        end
        4: if (!cs) begin m_phase = 2; m_left = CAL_N; end
        default: begin end
      endcase
    end
  endfunction

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
  endtask

  task automatic compare_model();
    chk3("mdl_state", seq_state, 3'(m_phase));
    chk1("mdl_hbm_rst_n", hbm_rst_n, (m_phase >= 2 && m_phase <= 4));
    chk1("mdl_user_rst_n", user_rst_n, (m_phase == 4));
    chk1("mdl_cattrip", HBM_CATTRIP, m_trip);
    chk1("mdl_cal_err", cal_err, m_calerr);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    m_step();
    @(negedge ap_clk);
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    passes         = 0;
    total          = 0;
    ap_rst_n       = 1'b0;
    pcie_perstn    = 1'b0;
    hbm_cal_done   = 1'b0;
    hbm_cattrip_in = 1'b0;
    m_reset();
    ticks(2);
    chk3("rst_state", seq_state, 3'd0);
    chk1("rst_hbm", hbm_rst_n, 1'b0);
    chk1("rst_user", user_rst_n, 1'b0);
    chk1("rst_trip", HBM_CATTRIP, 1'b0);
    chk1("rst_calerr", cal_err, 1'b0);
    ap_rst_n = 1'b1;
    ticks(2);
    chk3("idle_hold", seq_state, 3'd0);

    // Nominal bring-up
    pcie_perstn = 1'b1;
    ticks(3);
    chk3("nom_hbmrst_entry", seq_state, 3'd1);
    chk1("nom_hbm_low", hbm_rst_n, 1'b0);
    ticks(3);
    chk3("nom_hbmrst_3", seq_state, 3'd1);
    chk1("nom_hbm_low_3", hbm_rst_n, 1'b0);
    ticks(1);
    chk3("nom_waitcal", seq_state, 3'd2);
    chk1("nom_hbm_rise", hbm_rst_n, 1'b1);
    chk1("nom_user_low", user_rst_n, 1'b0);
    hbm_cal_done = 1'b1;
    ticks(2);
    chk3("nom_cal_sync", seq_state, 3'd2);
    ticks(1);
    chk3("nom_userrst", seq_state, 3'd3);
    chk1("nom_userrst_user", user_rst_n, 1'b0);
    ticks(2);
    chk3("nom_userrst_2", seq_state, 3'd3);
    ticks(1);
    chk3("nom_run", seq_state, 3'd4);
    chk1("nom_run_user", user_rst_n, 1'b1);
    chk1("nom_run_hbm", hbm_rst_n, 1'b1);

    // Calibration loss in RUN
    hbm_cal_done = 1'b0;
    ticks(3);
    chk3("loss_waitcal", seq_state, 3'd2);
    chk1("loss_user_low", user_rst_n, 1'b0);
    chk1("loss_hbm_high", hbm_rst_n, 1'b1);
    ticks(2);
    hbm_cal_done = 1'b1;
    ticks(3);
    chk3("loss_userrst", seq_state, 3'd3);
    ticks(2);
    chk1("loss_user_still_low", user_rst_n, 1'b0);
    ticks(1);
    chk3("loss_run", seq_state, 3'd4);
    chk1("loss_user_release", user_rst_n, 1'b1);

    // PERST# drop in RUN, then full restart with fresh counts
    pcie_perstn = 1'b0;
    ticks(2);
    chk3("perst_run_sync", seq_state, 3'd4);
    ticks(1);
    chk3("perst_run_idle", seq_state, 3'd0);
    chk1("perst_run_hbm", hbm_rst_n, 1'b0);
    chk1("perst_run_user", user_rst_n, 1'b0);
    pcie_perstn = 1'b1;
    ticks(6);
    chk3("restart_hbmrst", seq_state, 3'd1);
    ticks(1);
    chk3("restart_waitcal", seq_state, 3'd2);
    ticks(1);
    chk3("restart_userrst", seq_state, 3'd3);
    ticks(3);
    chk3("restart_run", seq_state, 3'd4);

    // PERST# drop during HBM_RST
    pcie_perstn = 1'b0;
    hbm_cal_done = 1'b0;
    ticks(3);
    chk3("drop_idle", seq_state, 3'd0);
    pcie_perstn = 1'b1;
    ticks(4);
    chk3("drop_in_hbmrst", seq_state, 3'd1);
    pcie_perstn = 1'b0;
    ticks(2);
    chk3("drop_hbmrst_sync", seq_state, 3'd1);
    ticks(1);
    chk3("drop_hbmrst_idle", seq_state, 3'd0);
    chk1("drop_hbmrst_hbm", hbm_rst_n, 1'b0);

    // Calibration timeout
    pcie_perstn = 1'b1;
    ticks(7);
    chk3("to_waitcal", seq_state, 3'd2);
    ticks(7);
    chk3("to_before", seq_state, 3'd2);
    chk1("to_before_err", cal_err, 1'b0);
    ticks(1);
    chk3("to_calerr", seq_state, 3'd5);
    chk1("to_err_set", cal_err, 1'b1);
    chk1("to_hbm_low", hbm_rst_n, 1'b0);
    ticks(5);
    chk3("to_stays", seq_state, 3'd5);
    pcie_perstn = 1'b0;
    ticks(3);
    chk3("to_clear_state", seq_state, 3'd0);
    chk1("to_clear_err", cal_err, 1'b0);

    // Timeout/calibration tie on the 8th WAIT_CAL cycle
    pcie_perstn = 1'b1;
    ticks(7);
    chk3("tie_waitcal", seq_state, 3'd2);
    ticks(5);
    hbm_cal_done = 1'b1;
    ticks(2);
    chk3("tie_last_cycle", seq_state, 3'd2);
    ticks(1);
    chk3("tie_userrst", seq_state, 3'd3);
    chk1("tie_no_err", cal_err, 1'b0);
    ticks(3);
    chk3("tie_run", seq_state, 3'd4);

    // Cattrip pulse in RUN
    hbm_cattrip_in = 1'b1;
    ticks(1);
    hbm_cattrip_in = 1'b0;
    ticks(1);
    chk1("trip_not_yet", HBM_CATTRIP, 1'b0);
    ticks(1);
    chk3("trip_fault", seq_state, 3'd6);
    chk1("trip_pin", HBM_CATTRIP, 1'b1);
    chk1("trip_hbm", hbm_rst_n, 1'b0);
    chk1("trip_user", user_rst_n, 1'b0);
    pcie_perstn = 1'b0;
    ticks(10);
    pcie_perstn = 1'b1;
    ticks(10);
    pcie_perstn = 1'b0;
    ticks(100);
    chk3("trip_persist_state", seq_state, 3'd6);
    chk1("trip_persist_pin", HBM_CATTRIP, 1'b1);
    ap_rst_n = 1'b0;
    #1;
    chk3("async_rst_state", seq_state, 3'd0);
    chk1("async_rst_pin", HBM_CATTRIP, 1'b0);
    chk1("async_rst_hbm", hbm_rst_n, 1'b0);
    ticks(2);
    ap_rst_n = 1'b1;

    // Randomized traffic against the model
    pcie_perstn  = 1'b1;
    hbm_cal_done = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (!ap_rst_n) begin
        if ($urandom_range(0, 2) == 0) ap_rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        ap_rst_n = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) pcie_perstn = ~pcie_perstn;
      if ($urandom_range(0, 14) == 0) hbm_cal_done = ~hbm_cal_done;
      hbm_cattrip_in = ($urandom_range(0, 1499) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
